mem_access_stage: RTL and testbench

- Pipeline memory stage between execute and writeback.
- Accepts one instruction at a time from execute. Performs the load or store on a single-master data-memory bus with a req/ack handshake.
- Sign- or zero-extends loaded data and delivers the ALU result, loaded data, data-select, dest register and write-enable to writeback with a one-cycle ready strobe.
- Non-memory instructions pass through in one cycle. Misaligned, illegal or timed-out accesses are flagged and suppress the register write.

---
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory stage between execute and writeback: performs loads/stores over a
// req/ack data bus, extends load data, and strobes results to writeback.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXMEM_valid,
    output logic        EXMEM_ready,
    input  logic [63:0] EXMEM_aluresult,
    input  logic [63:0] EXMEM_storedata,
    input  logic [5:0]  EXMEM_rd,
    input  logic        EXMEM_wbactive,
    input  logic        EXMEM_memread,
    input  logic        EXMEM_memwrite,
    input  logic [2:0]  EXMEM_funct3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        MEMWB_ready,
    output logic [5:0]  MEMWB_rd,
    output logic [63:0] MEMWB_aluresult,
    output logic [63:0] MEMWB_loadeddata,
    output logic        MEMWB_dataselect,
    output logic        MEMWB_wbactive,
    output logic        MEMWB_fault
);

    typedef enum logic {IDLE, BUS} state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    state_t      state, state_next;
    logic [7:0]  count;

    // Instruction held while the bus access is outstanding
    logic [5:0]  rd_p0;
    logic [63:0] alu_p0;
    logic [2:0]  funct3_p0;
    logic        wb_p0;
    logic        load_p0;

    logic        is_mem, illegal, misaligned, wb_eff;
    logic        do_pass, do_fault, do_start, do_done, do_timeout;

    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
        logic        [63:0] lane;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        lane = rdata >> {off, 3'b000};
        b    = lane[7:0];
        h    = lane[15:0];
        w    = lane[31:0];
        case (f3)
            3'b000:  return 64'(b);
            3'b001:  return 64'(h);
            3'b010:  return 64'(w);
            3'b011:  return lane;
            3'b100:  return {56'd0, lane[7:0]};
            3'b101:  return {48'd0, lane[15:0]};
            3'b110:  return {32'd0, lane[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [7:0] store_strobe(input logic [1:0] size,
                                                input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    assign EXMEM_ready = (state == IDLE) && !reset;

    assign is_mem  = EXMEM_memread || EXMEM_memwrite;
    assign illegal = (EXMEM_funct3 == 3'b111) || (EXMEM_funct3[2] && EXMEM_memwrite);
    assign wb_eff  = EXMEM_wbactive && (EXMEM_rd != 6'd0);

    always_comb begin
        misaligned = 1'b0;
        case (EXMEM_funct3[1:0])
            2'b01:   misaligned = EXMEM_aluresult[0];
            2'b10:   misaligned = (EXMEM_aluresult[1:0] != 2'b00);
            2'b11:   misaligned = (EXMEM_aluresult[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        do_pass    = 1'b0;
        do_fault   = 1'b0;
        do_start   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (EXMEM_valid && EXMEM_ready) begin
                    if (!is_mem)
                        do_pass = 1'b1;
                    else if (illegal || misaligned)
                        do_fault = 1'b1;
                    else begin
                        do_start   = 1'b1;
                        state_next = BUS;
                    end
                end
            end
            BUS: begin
                // An ack on the final allowed cycle wins over the timeout
                if (mem_ack) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end else if ({1'b0, count} + 9'd1 >= TIMEOUT_LIM) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count            <= 8'd0;
            rd_p0            <= 6'd0;
            alu_p0           <= 64'd0;
            funct3_p0        <= 3'd0;
            wb_p0            <= 1'b0;
            load_p0          <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= 64'd0;
            mem_wdata        <= 64'd0;
            mem_wstrb        <= 8'd0;
            MEMWB_ready      <= 1'b0;
            MEMWB_rd         <= 6'd0;
            MEMWB_aluresult  <= 64'd0;
            MEMWB_loadeddata <= 64'd0;
            MEMWB_dataselect <= 1'b0;
            MEMWB_wbactive   <= 1'b0;
            MEMWB_fault      <= 1'b0;
        end else begin
            state       <= state_next;
            MEMWB_ready <= 1'b0;

            if (do_pass || do_fault) begin
                MEMWB_ready      <= 1'b1;
                MEMWB_rd         <= EXMEM_rd;
                MEMWB_aluresult  <= EXMEM_aluresult;
                MEMWB_loadeddata <= 64'd0;
                MEMWB_dataselect <= 1'b0;
                MEMWB_wbactive   <= do_pass && wb_eff;
                MEMWB_fault      <= do_fault;
            end

            if (do_start) begin
                count     <= 8'd0;
                rd_p0     <= EXMEM_rd;
                alu_p0    <= EXMEM_aluresult;
                funct3_p0 <= EXMEM_funct3;
                wb_p0     <= wb_eff;
                load_p0   <= EXMEM_memread;
                mem_req   <= 1'b1;
                mem_we    <= EXMEM_memwrite;
                mem_addr  <= {EXMEM_aluresult[63:3], 3'b000};
                mem_wdata <= EXMEM_memwrite ?
                             (EXMEM_storedata << {EXMEM_aluresult[2:0], 3'b000}) : 64'd0;
                mem_wstrb <= EXMEM_memwrite ?
                             store_strobe(EXMEM_funct3[1:0], EXMEM_aluresult[2:0]) : 8'd0;
            end

            // Bus completion or abort: drop the request and strobe writeback
            if (do_done || do_timeout) begin
                mem_req          <= 1'b0;
                MEMWB_ready      <= 1'b1;
                MEMWB_rd         <= rd_p0;
                MEMWB_aluresult  <= alu_p0;
                MEMWB_fault      <= do_timeout;
                MEMWB_dataselect <= do_done && load_p0;
                MEMWB_wbactive   <= do_done && load_p0 && wb_p0;
                MEMWB_loadeddata <= (do_done && load_p0) ?
                                    load_extend(mem_rdata, alu_p0[2:0], funct3_p0) : 64'd0;
            end else if (state == BUS) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (built with TIMEOUT=4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EXMEM_valid;
    logic        EXMEM_ready;
    logic [63:0] EXMEM_aluresult;
    logic [63:0] EXMEM_storedata;
    logic [5:0]  EXMEM_rd;
    logic        EXMEM_wbactive;
    logic        EXMEM_memread;
    logic        EXMEM_memwrite;
    logic [2:0]  EXMEM_funct3;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        MEMWB_ready;
    logic [5:0]  MEMWB_rd;
    logic [63:0] MEMWB_aluresult;
    logic [63:0] MEMWB_loadeddata;
    logic        MEMWB_dataselect;
    logic        MEMWB_wbactive;
    logic        MEMWB_fault;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .EXMEM_valid(EXMEM_valid), .EXMEM_ready(EXMEM_ready),
        .EXMEM_aluresult(EXMEM_aluresult), .EXMEM_storedata(EXMEM_storedata),
        .EXMEM_rd(EXMEM_rd), .EXMEM_wbactive(EXMEM_wbactive),
        .EXMEM_memread(EXMEM_memread), .EXMEM_memwrite(EXMEM_memwrite),
        .EXMEM_funct3(EXMEM_funct3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .MEMWB_ready(MEMWB_ready), .MEMWB_rd(MEMWB_rd),
        .MEMWB_aluresult(MEMWB_aluresult), .MEMWB_loadeddata(MEMWB_loadeddata),
        .MEMWB_dataselect(MEMWB_dataselect), .MEMWB_wbactive(MEMWB_wbactive),
        .MEMWB_fault(MEMWB_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                         input logic [5:0] rd, input logic wb, input logic rdop,
                         input logic wrop, input logic [2:0] f3);
        EXMEM_valid     = v;
        EXMEM_aluresult = alu;
        EXMEM_storedata = sd;
        EXMEM_rd        = rd;
        EXMEM_wbactive  = wb;
        EXMEM_memread   = rdop;
        EXMEM_memwrite  = wrop;
        EXMEM_funct3    = f3;
    endtask

    task automatic idle_in();
        drive(1'b0, 64'd0, 64'd0, 6'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 64'd0; idle_in();
        step(); step();
        n_cmp++;
        if ({EXMEM_ready, mem_req, mem_we, mem_wstrb, MEMWB_ready, MEMWB_fault,
             MEMWB_wbactive, MEMWB_dataselect, MEMWB_rd} !== 20'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got ready=%b req=%b strb=%h mwb_ready=%b fault=%b, want all 0",
                              EXMEM_ready, mem_req, mem_wstrb, MEMWB_ready, MEMWB_fault);
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, MEMWB_aluresult, MEMWB_loadeddata} !== 256'd0) begin
            n_bad++; $display("FAIL reset_data: got addr=%h wdata=%h alu=%h ld=%h, want 0",
                              mem_addr, mem_wdata, MEMWB_aluresult, MEMWB_loadeddata);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (EXMEM_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: got %b want 1", EXMEM_ready);
        end
    endtask

    task automatic test_alu_op();
        drive(1'b1, 64'h1234, 64'd0, 6'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        idle_in();
        n_cmp++;
        if ({MEMWB_ready, MEMWB_dataselect, MEMWB_wbactive, MEMWB_fault, MEMWB_rd,
             MEMWB_aluresult, MEMWB_loadeddata, mem_req} !== {4'b1010, 6'd5, 64'h1234, 64'd0, 1'b0}) begin
            n_bad++; $display("FAIL alu_op: got rdy=%b sel=%b wb=%b flt=%b rd=%0d alu=%h ld=%h req=%b want 1 0 1 0 5 1234 0 0",
                              MEMWB_ready, MEMWB_dataselect, MEMWB_wbactive, MEMWB_fault,
                              MEMWB_rd, MEMWB_aluresult, MEMWB_loadeddata, mem_req);
        end
        step();
        n_cmp++;
        if ({MEMWB_ready, MEMWB_aluresult} !== {1'b0, 64'h1234}) begin
            n_bad++; $display("FAIL alu_hold: got rdy=%b alu=%h want 0 1234", MEMWB_ready, MEMWB_aluresult);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 64'hAAAA, 64'd0, 6'd1, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        n_cmp++;
        if ({MEMWB_ready, MEMWB_rd, MEMWB_aluresult, EXMEM_ready} !== {1'b1, 6'd1, 64'hAAAA, 1'b1}) begin
            n_bad++; $display("FAIL b2b_first: got rdy=%b rd=%0d alu=%h exr=%b want 1 1 aaaa 1",
                              MEMWB_ready, MEMWB_rd, MEMWB_aluresult, EXMEM_ready);
        end
        drive(1'b1, 64'hBBBB, 64'd0, 6'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        idle_in();
        n_cmp++;
        if ({MEMWB_ready, MEMWB_rd, MEMWB_aluresult, MEMWB_wbactive} !== {1'b1, 6'd0, 64'hBBBB, 1'b0}) begin
            n_bad++; $display("FAIL b2b_second_rd0: got rdy=%b rd=%0d alu=%h wb=%b want 1 0 bbbb 0",
                              MEMWB_ready, MEMWB_rd, MEMWB_aluresult, MEMWB_wbactive);
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [63:0] exp_ld, input string nm);
        drive(1'b1, 64'h1003, 64'd0, 6'd7, 1'b1, 1'b1, 1'b0, f3);
        step();
        idle_in();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, EXMEM_ready, MEMWB_ready} !==
            {1'b1, 1'b0, 64'h1000, 8'h00, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL %s_req: got req=%b we=%b addr=%h strb=%h exr=%b rdy=%b want 1 0 1000 00 0 0",
                              nm, mem_req, mem_we, mem_addr, mem_wstrb, EXMEM_ready, MEMWB_ready);
        end
        step(); step();
        mem_ack = 1'b1; mem_rdata = 64'h00000000_80000000;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_cmp++;
        if ({mem_req, MEMWB_ready, MEMWB_dataselect, MEMWB_wbactive, MEMWB_fault, MEMWB_rd,
             MEMWB_aluresult, MEMWB_loadeddata} !== {5'b01110, 6'd7, 64'h1003, exp_ld}) begin
            n_bad++; $display("FAIL %s_done: got req=%b rdy=%b sel=%b wb=%b flt=%b rd=%0d alu=%h ld=%h want ld=%h",
                              nm, mem_req, MEMWB_ready, MEMWB_dataselect, MEMWB_wbactive,
                              MEMWB_fault, MEMWB_rd, MEMWB_aluresult, MEMWB_loadeddata, exp_ld);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 64'h2004, 64'hDEADBEEF, 6'd3, 1'b1, 1'b0, 1'b1, 3'b010);
        step();
        idle_in();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !==
            {1'b1, 1'b1, 64'h2000, 8'hF0, 64'hDEADBEEF_00000000}) begin
            n_bad++; $display("FAIL sw_req: got req=%b we=%b addr=%h strb=%h wdata=%h want 1 1 2000 f0 deadbeef00000000",
                              mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, MEMWB_ready, MEMWB_wbactive, MEMWB_fault, MEMWB_dataselect} !== 5'b01000) begin
            n_bad++; $display("FAIL sw_done: got req=%b rdy=%b wb=%b flt=%b sel=%b want 0 1 0 0 0",
                              mem_req, MEMWB_ready, MEMWB_wbactive, MEMWB_fault, MEMWB_dataselect);
        end
        // SH at offset 6: strobe 0xC0, halfword in the top lane
        drive(1'b1, 64'h2006, 64'h0000BEEF, 6'd3, 1'b1, 1'b0, 1'b1, 3'b001);
        step();
        idle_in();
        n_cmp++;
        if ({mem_wstrb, mem_wdata} !== {8'hC0, 64'hBEEF0000_00000000}) begin
            n_bad++; $display("FAIL sh_lane: got strb=%h wdata=%h want c0 beef000000000000", mem_wstrb, mem_wdata);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic test_faults();
        drive(1'b1, 64'h3002, 64'd0, 6'd4, 1'b1, 1'b1, 1'b0, 3'b010);
        step();
        idle_in();
        n_cmp++;
        if ({mem_req, MEMWB_ready, MEMWB_fault, MEMWB_wbactive, EXMEM_ready} !== 5'b01101) begin
            n_bad++; $display("FAIL lw_misaligned: got req=%b rdy=%b flt=%b wb=%b exr=%b want 0 1 1 0 1",
                              mem_req, MEMWB_ready, MEMWB_fault, MEMWB_wbactive, EXMEM_ready);
        end
        drive(1'b1, 64'h3000, 64'd0, 6'd4, 1'b1, 1'b0, 1'b1, 3'b100);
        step();
        n_cmp++;
        if ({mem_req, MEMWB_ready, MEMWB_fault, MEMWB_wbactive} !== 4'b0110) begin
            n_bad++; $display("FAIL sbu_illegal: got req=%b rdy=%b flt=%b wb=%b want 0 1 1 0",
                              mem_req, MEMWB_ready, MEMWB_fault, MEMWB_wbactive);
        end
        drive(1'b1, 64'h3000, 64'd0, 6'd4, 1'b1, 1'b1, 1'b0, 3'b111);
        step();
        idle_in();
        n_cmp++;
        if ({mem_req, MEMWB_ready, MEMWB_fault} !== 3'b011) begin
            n_bad++; $display("FAIL f3_111_illegal: got req=%b rdy=%b flt=%b want 0 1 1",
                              mem_req, MEMWB_ready, MEMWB_fault);
        end
    endtask

    task automatic test_timeout();
        int high = 0;
        drive(1'b1, 64'h8, 64'd0, 6'd2, 1'b1, 1'b1, 1'b0, 3'b011);
        step();
        idle_in();
        for (int i = 0; i < 8 && mem_req; i++) begin
            high++;
            step();
        end
        n_cmp++;
        if (high !== 4) begin
            n_bad++; $display("FAIL timeout_req_cycles: got %0d want 4", high);
        end
        n_cmp++;
        if ({MEMWB_ready, MEMWB_fault, MEMWB_wbactive, MEMWB_dataselect} !== 4'b1100) begin
            n_bad++; $display("FAIL timeout_strobe: got rdy=%b flt=%b wb=%b sel=%b want 1 1 0 0",
                              MEMWB_ready, MEMWB_fault, MEMWB_wbactive, MEMWB_dataselect);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++;
        if ({MEMWB_ready, mem_req, EXMEM_ready} !== 3'b001) begin
            n_bad++; $display("FAIL stray_ack: got rdy=%b req=%b exr=%b want 0 0 1",
                              MEMWB_ready, mem_req, EXMEM_ready);
        end
    endtask

    task automatic test_ack_at_limit();
        drive(1'b1, 64'h10, 64'd0, 6'd6, 1'b1, 1'b1, 1'b0, 3'b011);
        step();
        idle_in();
        step(); step(); step();
        mem_ack = 1'b1; mem_rdata = 64'h11223344_55667788;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_cmp++;
        if ({MEMWB_ready, MEMWB_fault, MEMWB_wbactive, MEMWB_dataselect, MEMWB_loadeddata} !==
            {4'b1011, 64'h11223344_55667788}) begin
            n_bad++; $display("FAIL ack_at_limit: got rdy=%b flt=%b wb=%b sel=%b ld=%h want 1 0 1 1 1122334455667788",
                              MEMWB_ready, MEMWB_fault, MEMWB_wbactive, MEMWB_dataselect, MEMWB_loadeddata);
        end
    endtask

    task automatic test_reset_mid_bus();
        drive(1'b1, 64'h18, 64'd0, 6'd8, 1'b1, 1'b1, 1'b0, 3'b011);
        step();
        idle_in();
        step();
        reset = 1'b1;
        step();
        n_cmp++;
        if ({mem_req, MEMWB_ready, EXMEM_ready, mem_addr, MEMWB_aluresult, MEMWB_rd} !== 137'd0) begin
            n_bad++; $display("FAIL reset_mid_bus: got req=%b rdy=%b exr=%b addr=%h alu=%h rd=%0d want all 0",
                              mem_req, MEMWB_ready, EXMEM_ready, mem_addr, MEMWB_aluresult, MEMWB_rd);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({MEMWB_ready, EXMEM_ready} !== 2'b01) begin
            n_bad++; $display("FAIL after_reset_idle: got rdy=%b exr=%b want 0 1", MEMWB_ready, EXMEM_ready);
        end
        drive(1'b1, 64'h0, 64'd0, 6'd9, 1'b1, 1'b1, 1'b0, 3'b011);
        step();
        idle_in();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 64'h0}) begin
            n_bad++; $display("FAIL ld0_req: got req=%b addr=%h want 1 0", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 64'hCAFEBABE_12345678;
        step();
        mem_ack = 1'b0; mem_rdata = 64'd0;
        n_cmp++;
        if ({MEMWB_ready, MEMWB_fault, MEMWB_wbactive, MEMWB_rd, MEMWB_loadeddata} !==
            {3'b101, 6'd9, 64'hCAFEBABE_12345678}) begin
            n_bad++; $display("FAIL ld0_done: got rdy=%b flt=%b wb=%b rd=%0d ld=%h want 1 0 1 9 cafebabe12345678",
                              MEMWB_ready, MEMWB_fault, MEMWB_wbactive, MEMWB_rd, MEMWB_loadeddata);
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_back_to_back();
        test_load(3'b000, 64'hFFFFFFFF_FFFFFF80, "lb");
        test_load(3'b100, 64'h00000000_00000080, "lbu");
        test_store();
        test_faults();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
